// File: rtl/cm_pkg.sv
// Shared definitions for the cm arbiter family: arbitration orientation
// and a width-generic saturating adder.
package cm_pkg;

    typedef enum logic {
        ARB_MIN = 1'b0,
        ARB_MAX = 1'b1
    } t_arb_algo;

    localparam int SAT_MAX_W = 32;

    // Adds two operands and caps the result at 2^w-1; the extra sum bit keeps the carry.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [SAT_MAX_W:0] s;
        logic [SAT_MAX_W:0] cap;
        s   = {1'b0, a} + {1'b0, b};
        cap = ({{SAT_MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
        return (s > cap) ? cap[SAT_MAX_W-1:0] : s[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/cm_arb_age_if.sv
// Request/grant feedback and weight bundle between the arbiter front end and cm_arb_age.
interface cm_arb_age_if #(
    parameter int CH_CNT      = 2,
    parameter int WEIGHT_BITS = 8
);
    logic [CH_CNT-1:0]                  i_req;
    logic [CH_CNT-1:0]                  i_gnt;
    logic [CH_CNT-1:0][WEIGHT_BITS-1:0] i_base;
    logic                               i_clr;
    logic [CH_CNT-1:0][WEIGHT_BITS-1:0] o_weight;
    logic [CH_CNT-1:0]                  o_starve;
    logic                               o_starve_any;

    modport master (
        output i_req, i_gnt, i_base, i_clr,
        input  o_weight, o_starve, o_starve_any
    );

    modport slave (
        input  i_req, i_gnt, i_base, i_clr,
        output o_weight, o_starve, o_starve_any
    );
endinterface

// File: rtl/cm_arb_age_ch.sv
// One channel of the aging stage: age counter, clear priority, saturated
// base+age sum oriented for the downstream arbiter, and starvation flag.
module cm_arb_age_ch import cm_pkg::*; #(
    parameter int        WEIGHT_BITS = 8,
    parameter t_arb_algo ALGO        = ARB_MIN
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tick,
    input  logic                   i_clr,
    input  logic                   i_req,
    input  logic                   i_gnt,
    input  logic [WEIGHT_BITS-1:0] i_base,
    output logic [WEIGHT_BITS-1:0] o_weight,
    output logic                   o_starve
);

    localparam logic [WEIGHT_BITS-1:0] AGE_MAX = '1;

    logic [WEIGHT_BITS-1:0] age_p0;
    logic [WEIGHT_BITS-1:0] sum;

    // Age register: any clear source beats the tick, and a dropped request forfeits its age.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            age_p0 <= '0;
        end else if (i_clr || i_gnt || !i_req) begin
            age_p0 <= '0;
        end else if (i_tick && (age_p0 != AGE_MAX)) begin
            age_p0 <= age_p0 + 1'b1;
        end
    end

    always_comb begin
        sum      = WEIGHT_BITS'(sat_add(SAT_MAX_W'(i_base), SAT_MAX_W'(age_p0), WEIGHT_BITS));
        o_weight = (ALGO == ARB_MAX) ? sum : ~sum;
        o_starve = (age_p0 == AGE_MAX);
    end

endmodule

// File: rtl/cm_arb_age.sv
// Request-aging stage feeding cm_arb i_weight: free-running age prescaler
// shared by CH_CNT per-channel age/weight slices.
module cm_arb_age import cm_pkg::*; #(
    parameter int        CH_CNT       = 2,
    parameter int        WEIGHT_BITS  = 8,
    parameter int        AGE_STEP_CYC = 1,
    parameter t_arb_algo ALGO         = ARB_MIN
) (
    input  logic          i_clk,
    input  logic          i_rst,
    cm_arb_age_if.slave   bus
);

    if (CH_CNT < 1) begin : g_bad_ch_cnt
        $error("cm_arb_age: CH_CNT must be >= 1");
    end
    if (WEIGHT_BITS < 1 || WEIGHT_BITS >= SAT_MAX_W) begin : g_bad_weight_bits
        $error("cm_arb_age: WEIGHT_BITS must be in 1..SAT_MAX_W-1");
    end
    if (AGE_STEP_CYC < 1) begin : g_bad_age_step
        $error("cm_arb_age: AGE_STEP_CYC must be >= 1");
    end

    localparam int              PS_W    = $clog2((AGE_STEP_CYC < 2) ? 2 : AGE_STEP_CYC);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(AGE_STEP_CYC - 1);

    logic [PS_W-1:0]                    ps_p0;
    logic                               tick;
    logic [CH_CNT-1:0][WEIGHT_BITS-1:0] weight;
    logic [CH_CNT-1:0]                  starve;

    // Prescaler runs regardless of requests; with a step of 1 it stays at 0 and ticks every cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ps_p0 <= '0;
        end else if (bus.i_clr || (ps_p0 == PS_LAST)) begin
            ps_p0 <= '0;
        end else begin
            ps_p0 <= ps_p0 + 1'b1;
        end
    end

    assign tick = (ps_p0 == PS_LAST);

    for (genvar c = 0; c < CH_CNT; c++) begin : g_ch
        cm_arb_age_ch #(
            .WEIGHT_BITS (WEIGHT_BITS),
            .ALGO        (ALGO)
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_tick   (tick),
            .i_clr    (bus.i_clr),
            .i_req    (bus.i_req[c]),
            .i_gnt    (bus.i_gnt[c]),
            .i_base   (bus.i_base[c]),
            .o_weight (weight[c]),
            .o_starve (starve[c])
        );
    end

    assign bus.o_weight     = weight;
    assign bus.o_starve     = starve;
    assign bus.o_starve_any = |starve;

endmodule

// File: tb/tb_cm_arb_age.sv
// Directed bench for cm_arb_age: three instances (ARB_MAX, ARB_MIN, step-3
// prescaler) share one stimulus; expectations flow through a scoreboard queue.
module tb_cm_arb_age;
    import cm_pkg::*;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0][3:0] base;
    logic       clr;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    cm_arb_age_if #(.CH_CNT(2), .WEIGHT_BITS(4)) if_max ();
    cm_arb_age_if #(.CH_CNT(2), .WEIGHT_BITS(4)) if_min ();
    cm_arb_age_if #(.CH_CNT(2), .WEIGHT_BITS(4)) if_ps ();

    assign if_max.i_req = req;  assign if_max.i_gnt = gnt;
    assign if_max.i_base = base; assign if_max.i_clr = clr;
    assign if_min.i_req = req;  assign if_min.i_gnt = gnt;
    assign if_min.i_base = base; assign if_min.i_clr = clr;
    assign if_ps.i_req = req;   assign if_ps.i_gnt = gnt;
    assign if_ps.i_base = base;  assign if_ps.i_clr = clr;

    cm_arb_age #(.CH_CNT(2), .WEIGHT_BITS(4), .AGE_STEP_CYC(1), .ALGO(ARB_MAX))
        u_max (.i_clk(clk), .i_rst(rst_n), .bus(if_max));
    cm_arb_age #(.CH_CNT(2), .WEIGHT_BITS(4), .AGE_STEP_CYC(1), .ALGO(ARB_MIN))
        u_min (.i_clk(clk), .i_rst(rst_n), .bus(if_min));
    cm_arb_age #(.CH_CNT(2), .WEIGHT_BITS(4), .AGE_STEP_CYC(3), .ALGO(ARB_MAX))
        u_ps (.i_clk(clk), .i_rst(rst_n), .bus(if_ps));

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic exp_push(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic chk_pop(input logic [31:0] obs);
        exp_t e;
        n_tot++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    endtask

    // n rising edges, then return at the following falling edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        gnt   = '0;
        base  = '0;
        clr   = 1'b0;

        // Reset with no clock running
        exp_push("rst_weight_max", 32'h00);
        exp_push("rst_starve", 32'h0);
        exp_push("rst_starve_any", 32'h0);
        exp_push("rst_weight_min", 32'hFF);
        exp_push("rst_weight_ps", 32'h00);
        #3;
        chk_pop(32'(if_max.o_weight));
        chk_pop(32'(if_max.o_starve));
        chk_pop(32'(if_max.o_starve_any));
        chk_pop(32'(if_min.o_weight));
        chk_pop(32'(if_ps.o_weight));

        #2 rst_n = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);

        // Aging and saturation on channel 0
        req = 2'b01;
        exp_push("age5_weight", 32'h05);
        exp_push("age20_weight", 32'h0F);
        exp_push("age20_starve", 32'h1);
        exp_push("age20_starve_any", 32'h1);
        exp_push("age20_weight_min", 32'hF0);
        step(5);
        chk_pop(32'(if_max.o_weight));
        step(15);
        chk_pop(32'(if_max.o_weight));
        chk_pop(32'(if_max.o_starve));
        chk_pop(32'(if_max.o_starve_any));
        chk_pop(32'(if_min.o_weight));

        // Grant clears a saturated age, then aging resumes
        gnt = 2'b01;
        exp_push("gnt_clear_weight", 32'h00);
        exp_push("gnt_clear_starve", 32'h0);
        exp_push("gnt_resume1", 32'h01);
        exp_push("gnt_resume2", 32'h02);
        exp_push("resat_starve", 32'h1);
        step(1);
        gnt = 2'b00;
        chk_pop(32'(if_max.o_weight));
        chk_pop(32'(if_max.o_starve));
        step(1);
        chk_pop(32'(if_max.o_weight));
        step(1);
        chk_pop(32'(if_max.o_weight));
        step(13);
        chk_pop(32'(if_max.o_starve));

        // Same with i_clr
        clr = 1'b1;
        exp_push("clr_clear_weight", 32'h00);
        exp_push("clr_resume1", 32'h01);
        exp_push("clr_resume2", 32'h02);
        step(1);
        clr = 1'b0;
        chk_pop(32'(if_max.o_weight));
        step(1);
        chk_pop(32'(if_max.o_weight));
        step(1);
        chk_pop(32'(if_max.o_weight));

        // Base + age saturation on channel 1; channel 0 drops its request
        base[1] = 4'd12;
        req = 2'b10;
        exp_push("base_age2_weight", 32'hE0);
        exp_push("base_sat_weight", 32'hF0);
        exp_push("base_sat_weight_min", 32'h0F);
        exp_push("base_sat_no_starve", 32'h0);
        step(2);
        chk_pop(32'(if_max.o_weight));
        step(4);
        chk_pop(32'(if_max.o_weight));
        chk_pop(32'(if_min.o_weight));
        chk_pop(32'(if_max.o_starve));

        // Prescaler with step 3
        base = '0;
        req  = 2'b00;
        clr  = 1'b1;
        step(1);
        clr = 1'b0;
        req = 2'b01;
        exp_push("ps_8edges", 32'h02);
        exp_push("ps_9edges", 32'h03);
        exp_push("ps_req_drop", 32'h00);
        exp_push("ps_reage", 32'h01);
        exp_push("ps_gnt_tick", 32'h00);
        step(8);
        chk_pop(32'(if_ps.o_weight));
        step(1);
        chk_pop(32'(if_ps.o_weight));
        req = 2'b00;
        step(1);
        chk_pop(32'(if_ps.o_weight));
        req = 2'b01;
        step(2);
        chk_pop(32'(if_ps.o_weight));
        step(2);
        gnt = 2'b01;
        step(1);
        gnt = 2'b00;
        chk_pop(32'(if_ps.o_weight));

        // Reset mid-count from ages {7,3}
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        req = 2'b01;
        step(4);
        req = 2'b11;
        exp_push("pre_rst_weight", 32'h37);
        exp_push("mid_rst_weight", 32'h00);
        exp_push("mid_rst_starve", 32'h0);
        exp_push("mid_rst_weight_min", 32'hFF);
        exp_push("post_rst_weight", 32'h10);
        exp_push("post_rst_ps_no_tick", 32'h00);
        exp_push("post_rst_ps_tick", 32'h10);
        step(3);
        chk_pop(32'(if_max.o_weight));
        #2 rst_n = 1'b0;
        #1;
        chk_pop(32'(if_max.o_weight));
        chk_pop(32'(if_max.o_starve));
        chk_pop(32'(if_min.o_weight));
        #1 rst_n = 1'b1;
        req = 2'b10;
        step(1);
        chk_pop(32'(if_max.o_weight));
        chk_pop(32'(if_ps.o_weight));
        step(2);
        chk_pop(32'(if_ps.o_weight));

        if (sb.size() != 0) begin
            n_tot++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cm_arb_age.md
Name: cm_arb_age

Overview:
- Request-aging stage directly upstream of the weighted arbiter cm_arb; generates its i_weight vector.
- Counts how long each channel's request has waited without a grant and adds a static base priority. Saturates the sum to WEIGHT_BITS.
- Orients the weight for the arbiter's ALGO, so starving channels win under both ARB_MIN and ARB_MAX.
- Consumes the arbiter's o_gnt as feedback to clear ages.

Parameters:
- CH_CNT, 2: number of requesting channels (>=1).
- WEIGHT_BITS, 8: width of age counters, base priority and output weight (>=1).
- AGE_STEP_CYC, 1: clock cycles per age increment (>=1); 1 means age every cycle.
- ALGO, ARB_MIN: t_arb_algo of the downstream arbiter; selects output weight orientation.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_req  in  CH_CNT  per-channel request, same vector as fed to cm_arb.
- i_gnt  in  CH_CNT  grant feedback from cm_arb o_gnt; nominally one-hot or zero.
- i_base  in  CH_CNT x WEIGHT_BITS  static per-channel base priority; larger means more urgent.
- i_clr  in  1  synchronous clear of all ages.
- o_weight  out  CH_CNT x WEIGHT_BITS  weight vector for cm_arb i_weight.
- o_starve  out  CH_CNT  per-channel flag: age counter saturated.
- o_starve_any  out  1  OR of o_starve.

Behaviour:
- Reset (i_rst=0, asynchronous, no clock needed):
  - Prescaler = 0; all ages = 0.
  - o_starve = 0 and o_starve_any = 0.
  - o_weight = i_base oriented per ALGO: i_base for ARB_MAX, ~i_base for ARB_MIN; with base 0 that is 0 or all-ones.
- Prescaler:
  - Counts 0..AGE_STEP_CYC-1, then wraps to 0.
  - tick = 1 when the count equals AGE_STEP_CYC-1; for AGE_STEP_CYC=1, tick is constant 1.
  - Free-running: not gated by i_req.
  - i_clr resets the prescaler to 0.
  - Width is $clog2 of max(AGE_STEP_CYC,2).
- Per-channel age register, next value by priority:
  1. i_clr=1: 0.
  2. i_gnt[c]=1: 0. Applies even if i_req[c]=0.
  3. i_req[c]=0: 0. A dropped request loses its accumulated age.
  4. tick=1: saturating increment, age+1 capped at 2^WEIGHT_BITS-1. Never wraps.
  5. Otherwise: hold.
- Multi-hot i_gnt is tolerated: each asserted bit clears only its own channel.
- Weight datapath (combinational from age flops and i_base; zero added latency):
  - sum = i_base[c] + age[c] in WEIGHT_BITS+1 bits, saturated to 2^WEIGHT_BITS-1.
  - ARB_MAX: o_weight[c] = sum.
  - ARB_MIN: o_weight[c] = bitwise-NOT of sum (smallest value = most urgent).
- Effective latency:
  - An age increment is visible on o_weight the cycle after the tick edge.
  - A grant at edge N gives weight = oriented base from cycle N+1.
- o_starve[c] = (age[c] == all-ones), combinational from flops. It drops in the same cycle the age clears.
- Simultaneous events:
  - i_gnt[c] and tick in the same cycle: clear wins.
  - i_req rise and tick in the same cycle: age goes 0→1 at that edge.
- Reset deasserting mid-operation resumes from all-zero state; no re-sync of the prescaler to arbiter activity.

Decomposition:
- cm_pkg owns:
  - t_arb_algo (ARB_MIN, ARB_MAX), shared with cm_arb.
  - A saturating-add function, parameterised via width-generic implementation on WEIGHT_BITS+1 bits.
- Sub-module cm_arb_age_ch:
  - Contents: one channel's age register, clear/increment priority logic, saturating sum, orientation, starve flag.
  - Instantiated CH_CNT times in a generate loop.
  - The prescaler stays in the top level and fans out tick.
- Top also hosts parameter legality assertions: CH_CNT>=1, WEIGHT_BITS>=1, AGE_STEP_CYC>=1.

Test Plan:
All scenarios use CH_CNT=2, WEIGHT_BITS=4, AGE_STEP_CYC=1, ALGO=ARB_MAX, i_base=0 unless stated.
1. Reset: hold i_rst=0, toggle no clock -> o_weight={0,0}, o_starve=0, o_starve_any=0. With ALGO=ARB_MIN -> o_weight={4'hF,4'hF}.
2. Aging and saturation:
   - i_req=2'b01 for 5 edges, i_gnt=0 -> o_weight[0]=5, o_weight[1]=0.
   - Continue to 20 edges -> o_weight[0] holds 15, o_starve[0]=1, o_starve_any=1.
3. Clear paths:
   - From age 15 with i_req[0] held, pulse i_gnt[0] one cycle -> next cycle o_weight[0]=0, o_starve[0]=0, then resumes 1,2,...
   - Same sequence using i_clr instead -> identical response.
4. Base saturation: i_base[1]=12, i_req[1] held 6 edges -> o_weight[1]=15, not 2. Under ALGO=ARB_MIN -> 0.
5. Prescaler and request drop:
   - AGE_STEP_CYC=3, i_req[0] held 9 edges -> o_weight[0]=3.
   - Drop i_req[0] one cycle -> 0.
   - Grant and tick coincident -> 0.
6. Reset mid-count: ages {7,3}, assert i_rst=0 between clock edges -> outputs zero immediately. After release, first tick gives age 1 only for requesting channels.
